sim_ctrl_mon: RTL and testbench

//  Synthesizable simulation/FPGA run-control monitor for the SoC. Passively snoops the CPU
//  AHB-Lite master for writes to a control address, decodes PASS/FAIL codes, streams other

---
 rtl/sim_ctrl_mon.sv | 147 ++++++++++++++
 tb/tb_sim_ctrl_mon.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl_mon.sv
// Run-control monitor: snoops CPU AHB writes to a control address for PASS/FAIL codes,
// buffers console bytes, watches for retire stalls and counts retired instructions.
module sim_ctrl_mon #(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  CTRL_ADDR  = 32'h6000fff8,
    parameter int unsigned        NUM_LANES  = 1,
    parameter int unsigned        WDT_WINDOW = 5000,
    parameter int unsigned        FIFO_DEPTH = 16,
    parameter logic [31:0]        PC_THRESH  = 32'h00000ad4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic [1:0]              ahb_htrans,
    input  logic [ADDR_W-1:0]       ahb_haddr,
    input  logic                    ahb_hwrite,
    input  logic                    ahb_hready,
    input  logic [31:0]             ahb_hwdata,
    input  logic [NUM_LANES-1:0]    rtu_retire,
    input  logic [NUM_LANES*32-1:0] rtu_retire_pc,
    output logic                    con_vld,
    output logic [7:0]              con_char,
    input  logic                    con_rdy,
    output logic                    sim_done,
    output logic [1:0]              sim_result,
    output logic [31:0]             instret_cnt,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned WIN_W = $clog2(WDT_WINDOW);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic               cap_q, cap_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               seen_q, seen_d;
    logic [31:0]        instret_q, instret_d;
    logic [7:0]         drop_q, drop_d;
    logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
    logic [7:0]         mem [FIFO_DEPTH];

    logic [NUM_LANES-1:0] lane_hit;
    logic [31:0]          hit_cnt;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lane_hit[gi] = rtu_retire[gi] && (rtu_retire_pc[32*gi +: 32] > PC_THRESH);
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cnt = hit_cnt + 32'(lane_hit[i]);
        end
    end

    // The data phase of a captured control write completes on the next hready edge.
    logic data_ph, is_pass, is_fail, running, push_req;
    assign data_ph  = ahb_hready && cap_q;
    assign is_pass  = data_ph && (ahb_hwdata == 32'h00000fff || ahb_hwdata == 32'hffff0000);
    assign is_fail  = data_ph && (ahb_hwdata == 32'h00000eee || ahb_hwdata == 32'heeee0000);
    assign running  = (state_q == ST_RUN);
    assign push_req = running && data_ph && !is_pass && !is_fail;

    logic empty, full, pop, push_ok, drop_ev;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop     = !empty && con_rdy;
    assign push_ok = push_req && (!full || pop);
    assign drop_ev = push_req && full && !pop;

    logic win_last, any_ret, timeout;
    assign win_last = (win_q == WIN_W'(WDT_WINDOW - 1));
    assign any_ret  = |rtu_retire;
    assign timeout  = win_last && !seen_q && !any_ret;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        seen_d    = seen_q;
        instret_d = instret_q;
        cap_d     = cap_q;
        drop_d    = drop_q;
        if (ahb_hready) begin
            cap_d = ahb_htrans[1] && ahb_hwrite && (ahb_haddr == CTRL_ADDR);
        end
        if (drop_ev && drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
        end
        if (running) begin
            instret_d = instret_q + hit_cnt;
            if (win_last) begin
                win_d  = '0;
                seen_d = 1'b0;
            end else begin
                win_d  = win_q + 1'b1;
                seen_d = seen_q || any_ret;
            end
            // A decoded code on the same edge as a timeout takes precedence.
            if (is_pass)      state_d = ST_PASS;
            else if (is_fail) state_d = ST_FAIL;
            else if (timeout) state_d = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_RUN;
            cap_q     <= 1'b0;
            win_q     <= '0;
            seen_q    <= 1'b0;
            instret_q <= '0;
            drop_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            win_q     <= win_d;
            seen_q    <= seen_d;
            instret_q <= instret_d;
            drop_q    <= drop_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= ahb_hwdata[7:0];
        end
    end

    assign con_vld     = !empty;
    assign con_char    = empty ? 8'h00 : mem[rd_ptr_q[PTR_W-1:0]];
    assign sim_done    = (state_q != ST_RUN);
    assign sim_result  = state_q;
    assign instret_cnt = instret_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_sim_ctrl_mon.sv
// Bench for sim_ctrl_mon: directed scenarios plus random traffic, all checked every cycle
// against a queue-based reference model of the monitor.
module tb_sim_ctrl_mon;

    localparam logic [31:0] CTRL   = 32'h6000fff8;
    localparam logic [31:0] THRESH = 32'h00000ad4;
    localparam int NL = 2;
    localparam int W  = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic [1:0]    ahb_htrans = '0;
    logic [31:0]   ahb_haddr = '0;
    logic          ahb_hwrite = 1'b0;
    logic          ahb_hready = 1'b1;
    logic [31:0]   ahb_hwdata = '0;
    logic [NL-1:0] rtu_retire = '0;
    logic [NL*32-1:0] rtu_retire_pc = '0;
    logic          con_vld;
    logic [7:0]    con_char;
    logic          con_rdy = 1'b0;
    logic          sim_done;
    logic [1:0]    sim_result;
    logic [31:0]   instret_cnt;
    logic [7:0]    drop_cnt;

    sim_ctrl_mon #(
        .ADDR_W(32), .CTRL_ADDR(CTRL), .NUM_LANES(NL),
        .WDT_WINDOW(W), .FIFO_DEPTH(D), .PC_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .ahb_htrans(ahb_htrans), .ahb_haddr(ahb_haddr), .ahb_hwrite(ahb_hwrite),
        .ahb_hready(ahb_hready), .ahb_hwdata(ahb_hwdata),
        .rtu_retire(rtu_retire), .rtu_retire_pc(rtu_retire_pc),
        .con_vld(con_vld), .con_char(con_char), .con_rdy(con_rdy),
        .sim_done(sim_done), .sim_result(sim_result),
        .instret_cnt(instret_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    logic [1:0]  m_res;
    bit          m_cap;
    int          m_cyc;
    bit          m_seen;
    logic [31:0] m_inst;
    int          m_drop;
    logic [7:0]  got[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_res = 2'b00; m_cap = 0; m_cyc = 0; m_seen = 0; m_inst = '0; m_drop = 0;
        got.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit run, dph, pass, fail, pop, any, last, to;
        run  = (m_res == 2'b00);
        dph  = ahb_hready && m_cap;
        pass = dph && (ahb_hwdata == 32'h00000fff || ahb_hwdata == 32'hffff0000);
        fail = dph && (ahb_hwdata == 32'h00000eee || ahb_hwdata == 32'heeee0000);
        pop  = (m_q.size() != 0) && con_rdy;
        if (pop) void'(m_q.pop_front());
        if (run && dph && !pass && !fail) begin
            if (m_q.size() < D) m_q.push_back(ahb_hwdata[7:0]);
            else if (m_drop < 255) m_drop++;
        end
        if (run) begin
            for (int i = 0; i < NL; i++)
                if (rtu_retire[i] && rtu_retire_pc[32*i +: 32] > THRESH) m_inst = m_inst + 1;
            any  = (rtu_retire != 0);
            last = ((m_cyc % W) == W - 1);
            to   = last && !m_seen && !any;
            m_seen = last ? 1'b0 : (m_seen || any);
            m_cyc++;
            if (pass)      m_res = 2'b01;
            else if (fail) m_res = 2'b10;
            else if (to)   m_res = 2'b11;
        end
        if (ahb_hready) m_cap = ahb_htrans[1] && ahb_hwrite && (ahb_haddr == CTRL);
    endtask

    task automatic compare();
        chk("con_vld", {31'b0, con_vld}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) chk("con_char", {24'b0, con_char}, {24'b0, m_q[0]});
        chk("sim_done", {31'b0, sim_done}, {31'b0, m_res != 2'b00});
        chk("sim_result", {30'b0, sim_result}, {30'b0, m_res});
        chk("instret_cnt", instret_cnt, m_inst);
        chk("drop_cnt", {24'b0, drop_cnt}, 32'(m_drop));
    endtask

    task automatic step();
        if (con_vld && con_rdy) got.push_back(con_char);
        model_edge();
        @(posedge clk); #1;
        compare();
    endtask

    task automatic do_reset();
        #2 rst_b = 1'b0;
        #1;
        chk("rst_con_vld", {31'b0, con_vld}, 32'd0);
        chk("rst_con_char", {24'b0, con_char}, 32'd0);
        chk("rst_sim_done", {31'b0, sim_done}, 32'd0);
        chk("rst_sim_result", {30'b0, sim_result}, 32'd0);
        chk("rst_instret", instret_cnt, 32'd0);
        chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic ahb_write(input logic [31:0] data, input bit seq, input int waits);
        ahb_htrans = seq ? 2'b11 : 2'b10;
        ahb_haddr = CTRL; ahb_hwrite = 1'b1; ahb_hready = 1'b1;
        step();
        ahb_htrans = 2'b00; ahb_hwrite = 1'b0; ahb_haddr = '0; ahb_hwdata = data;
        repeat (waits) begin
            ahb_hready = 1'b0;
            step();
        end
        ahb_hready = 1'b1;
        step();
        ahb_hwdata = '0;
    endtask

    task automatic keepalive(input bit on);
        rtu_retire = on ? 2'b01 : 2'b00;
        rtu_retire_pc = '0;
    endtask

    task automatic rand_seg(input int n, input int ret_pct);
        int sel;
        for (int c = 0; c < n; c++) begin
            ahb_hready = ($urandom_range(0, 3) != 0);
            ahb_htrans = 2'($urandom_range(0, 3));
            ahb_hwrite = ($urandom_range(0, 3) != 0);
            ahb_haddr  = ($urandom_range(0, 2) != 0) ? CTRL : $urandom;
            sel = $urandom_range(0, 1199);
            case (sel)
                0: ahb_hwdata = 32'h00000fff;
                1: ahb_hwdata = 32'hffff0000;
                2: ahb_hwdata = 32'h00000eee;
                3: ahb_hwdata = 32'heeee0000;
                default: ahb_hwdata = $urandom;
            endcase
            con_rdy = 1'($urandom_range(0, 1));
            for (int i = 0; i < NL; i++) begin
                rtu_retire[i] = ($urandom_range(0, 99) < ret_pct);
                case ($urandom_range(0, 3))
                    0: rtu_retire_pc[32*i +: 32] = THRESH;
                    1: rtu_retire_pc[32*i +: 32] = THRESH + 1;
                    2: rtu_retire_pc[32*i +: 32] = 32'h0;
                    default: rtu_retire_pc[32*i +: 32] = $urandom;
                endcase
            end
            step();
        end
        ahb_htrans = 2'b00; ahb_hwrite = 1'b0; ahb_hready = 1'b1;
    endtask

    initial begin
        // Reset state and console bytes 'A','B'
        do_reset();
        keepalive(1); con_rdy = 1'b1;
        ahb_write(32'h41, 0, 0);
        ahb_write(32'h42, 0, 0);
        repeat (3) step();
        chk("ab_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("ab_first", {24'b0, got[0]}, 32'h41);
            chk("ab_second", {24'b0, got[1]}, 32'h42);
        end
        chk("ab_result", {30'b0, sim_result}, 32'd0);

        // PASS with two wait states
        do_reset();
        keepalive(1);
        ahb_htrans = 2'b10; ahb_haddr = CTRL; ahb_hwrite = 1'b1; ahb_hready = 1'b1;
        step();
        ahb_htrans = 2'b00; ahb_hwrite = 1'b0; ahb_haddr = '0; ahb_hwdata = 32'h00000fff;
        ahb_hready = 1'b0;
        step(); chk("pass_wait1_done", {31'b0, sim_done}, 32'd0);
        step(); chk("pass_wait2_done", {31'b0, sim_done}, 32'd0);
        ahb_hready = 1'b1;
        step();
        chk("pass_done", {31'b0, sim_done}, 32'd1);
        chk("pass_result", {30'b0, sim_result}, 32'd1);
        ahb_hwdata = '0;

        // FAIL via SEQ beat, then PASS code ignored
        do_reset();
        keepalive(1);
        ahb_write(32'heeee0000, 1, 0);
        chk("fail_result", {30'b0, sim_result}, 32'd2);
        ahb_write(32'h00000fff, 0, 1);
        repeat (2) step();
        chk("fail_sticky", {30'b0, sim_result}, 32'd2);

        // Watchdog: no retires times out at window end
        do_reset();
        keepalive(0);
        repeat (7) step();
        chk("wdt_pre", {30'b0, sim_result}, 32'd0);
        step();
        chk("wdt_timeout", {30'b0, sim_result}, 32'd3);

        // Watchdog: retire on the last window cycle rescues it
        do_reset();
        keepalive(0);
        repeat (7) step();
        rtu_retire = 2'b01;
        step();
        rtu_retire = 2'b00;
        chk("wdt_rescue", {30'b0, sim_result}, 32'd0);
        repeat (7) step();
        chk("wdt_second_pre", {30'b0, sim_result}, 32'd0);
        step();
        chk("wdt_second", {30'b0, sim_result}, 32'd3);

        // Instret counting with pc threshold
        do_reset();
        rtu_retire = 2'b11;
        rtu_retire_pc = {32'h00000b00, 32'h00000b00};
        step(); chk("inst_two", instret_cnt, 32'd2);
        rtu_retire = 2'b01;
        rtu_retire_pc = {32'h0, 32'h00000100};
        step(); chk("inst_low_pc", instret_cnt, 32'd2);
        rtu_retire = 2'b11;
        rtu_retire_pc = {32'h00000ad5, 32'h00000ad4};
        step(); chk("inst_boundary", instret_cnt, 32'd3);
        keepalive(1);

        // FIFO full: 6 chars, 2 dropped, 4 drained in order
        do_reset();
        keepalive(1); con_rdy = 1'b0;
        for (int k = 0; k < 6; k++) ahb_write(32'h61 + k, 0, 0);
        chk("full_drop", {24'b0, drop_cnt}, 32'd2);
        chk("full_vld", {31'b0, con_vld}, 32'd1);
        con_rdy = 1'b1;
        repeat (6) step();
        chk("full_drain_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk("full_drain_byte", {24'b0, got[k]}, 32'h61 + k);

        // Drop counter saturation
        do_reset();
        keepalive(1); con_rdy = 1'b0;
        for (int k = 0; k < 262; k++) ahb_write(32'h100 + k, 0, 0);
        chk("drop_sat", {24'b0, drop_cnt}, 32'd255);

        // Reset in the middle of a transfer discards the captured address phase
        do_reset();
        keepalive(1); con_rdy = 1'b1;
        ahb_htrans = 2'b10; ahb_haddr = CTRL; ahb_hwrite = 1'b1; ahb_hready = 1'b1;
        step();
        ahb_htrans = 2'b00; ahb_hwrite = 1'b0; ahb_haddr = '0;
        do_reset();
        ahb_hwdata = 32'h5a;
        step();
        step();
        chk("midrst_vld", {31'b0, con_vld}, 32'd0);
        chk("midrst_got", got.size(), 0);
        ahb_hwdata = '0;

        // Random traffic at several retire densities
        do_reset(); rand_seg(400, 70);
        do_reset(); rand_seg(400, 30);
        do_reset(); rand_seg(300, 5);
        do_reset(); rand_seg(300, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
